// File: rtl/text_overlay_gen.sv
// text_overlay_gen: text overlay for the VGA game screen (logo, score line,
// blinking GAME OVER). Two-stage pixel pipeline in front of a synchronous
// ASCII font ROM (8x16 glyphs, 1-cycle read), plus a TITLE/PLAY/OVER mode FSM
// whose transitions are taken only on frame_tick.
// Optional build macro: TEXT_LEAD_BLANK_EN (blank leading zero score digits).
module text_overlay_gen #(
    parameter int          NUM_DIGITS   = 2,
    parameter int          SCORE_Y      = 32,
    parameter int          BLINK_FRAMES = 30,
    parameter int          OVER_FRAMES  = 300,
    parameter logic [11:0] BG_RGB       = 12'hF8C,
    parameter logic [11:0] SCORE_RGB    = 12'h000,
    parameter logic [11:0] OVER_RGB     = 12'hF00,
    parameter logic [11:0] LOGO_RGB     = 12'h00F
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [9:0]              x,
    input  logic [9:0]              y,
    input  logic                    frame_tick,
    input  logic                    game_start,
    input  logic                    game_over,
    input  logic [4*NUM_DIGITS-1:0] score_a,
    input  logic [4*NUM_DIGITS-1:0] score_b,
    output logic [10:0]             rom_addr_o,
    input  logic [7:0]              rom_data_i,
    output logic [2:0]              text_on,
    output logic [11:0]             text_rgb
);

`ifdef TEXT_LEAD_BLANK_EN
    localparam bit LEAD_BLANK = 1'b1;
`else
    localparam bit LEAD_BLANK = 1'b0;
`endif

    typedef enum logic [1:0] {ST_TITLE = 2'd0, ST_PLAY = 2'd1, ST_OVER = 2'd2} state_t;

    state_t      state_q, state_d;
    logic        pend_start_q, pend_start_d;
    logic        pend_over_q, pend_over_d;
    logic [15:0] over_cnt_q, over_cnt_d;
    logic [15:0] blink_cnt_q, blink_cnt_d;
    logic        blink_on_q, blink_on_d;

    logic        logo_hit, score_hit, over_hit;
    logic [6:0]  char_s0;
    logic [3:0]  row_s0;
    logic [2:0]  bit_s0;
    logic [11:0] rgb_s0;
    logic [3:0]  oidx;
    logic [1:0]  lidx;

    logic [2:0]  on_p1_q;
    logic [2:0]  bit_p1_q;
    logic [11:0] rgb_p1_q;
    logic [2:0]  text_on_q;
    logic [11:0] text_rgb_q;

    function automatic logic [6:0] logo_char(input logic [1:0] i);
        case (i)
            2'd0:    logo_char = 7'h50; // P
            2'd1:    logo_char = 7'h4F; // O
            2'd2:    logo_char = 7'h4E; // N
            default: logo_char = 7'h47; // G
        endcase
    endfunction

    function automatic logic [6:0] over_char(input logic [3:0] i);
        case (i)
            4'd0:    over_char = 7'h47; // G
            4'd1:    over_char = 7'h41; // A
            4'd2:    over_char = 7'h4D; // M
            4'd3:    over_char = 7'h45; // E
            4'd4:    over_char = 7'h20; // space
            4'd5:    over_char = 7'h4F; // O
            4'd6:    over_char = 7'h56; // V
            4'd7:    over_char = 7'h45; // E
            default: over_char = 7'h52; // R
        endcase
    endfunction

    // Digit i counts from the most significant nibble; nibbles above 9 print '?'.
    function automatic logic [6:0] digit_char(input logic [4*NUM_DIGITS-1:0] s, input int i);
        logic [3:0] d;
        logic       lead;
        d = s[4*(NUM_DIGITS-1-i) +: 4];
        digit_char = (d > 4'd9) ? 7'h3F : {3'b011, d};
        lead = 1'b1;
        for (int k = 0; k < NUM_DIGITS-1; k++) begin
            if (k <= i && s[4*(NUM_DIGITS-1-k) +: 4] != 4'd0) lead = 1'b0;
        end
        // The least significant digit is never blanked so a zero score reads "0".
        if (LEAD_BLANK && i < NUM_DIGITS-1 && lead) digit_char = 7'h00;
    endfunction

    function automatic logic [6:0] score_char(input logic [5:0] col,
                                              input logic [4*NUM_DIGITS-1:0] sa,
                                              input logic [4*NUM_DIGITS-1:0] sb);
        int c;
        c = int'(col);
        score_char = 7'h00;
        case (c)
            2: score_char = 7'h53; // S
            3: score_char = 7'h43; // C
            4: score_char = 7'h4F; // O
            5: score_char = 7'h52; // R
            6: score_char = 7'h45; // E
            7: score_char = 7'h3A; // :
            default: begin
                if (c >= 8 && c < 8 + NUM_DIGITS)
                    score_char = digit_char(sa, c - 8);
                else if (c == 8 + NUM_DIGITS)
                    score_char = 7'h2D;
                else if (c > 8 + NUM_DIGITS && c <= 8 + 2*NUM_DIGITS)
                    score_char = digit_char(sb, c - 9 - NUM_DIGITS);
            end
        endcase
    endfunction

    // Mode state, latched requests and OVER frame/blink counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_TITLE;
            pend_start_q <= 1'b0;
            pend_over_q  <= 1'b0;
            over_cnt_q   <= 16'd0;
            blink_cnt_q  <= 16'd0;
            blink_on_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_start_q <= pend_start_d;
            pend_over_q  <= pend_over_d;
            over_cnt_q   <= over_cnt_d;
            blink_cnt_q  <= blink_cnt_d;
            blink_on_q   <= blink_on_d;
        end
    end

    // Requests accumulate between frames and are resolved (then cleared) on frame_tick.
    always_comb begin
        state_d      = state_q;
        pend_start_d = pend_start_q | game_start;
        pend_over_d  = pend_over_q | game_over;
        over_cnt_d   = over_cnt_q;
        blink_cnt_d  = blink_cnt_q;
        blink_on_d   = blink_on_q;
        if (frame_tick) begin
            pend_start_d = 1'b0;
            pend_over_d  = 1'b0;
            case (state_q)
                ST_TITLE: if (pend_start_q | game_start) state_d = ST_PLAY;
                ST_PLAY: begin
                    if (pend_over_q | game_over) begin
                        state_d     = ST_OVER;
                        over_cnt_d  = 16'd0;
                        blink_cnt_d = 16'd0;
                        blink_on_d  = 1'b1;
                    end
                end
                ST_OVER: begin
                    if (pend_start_q | game_start) begin
                        state_d = ST_TITLE;
                    end else if (OVER_FRAMES != 0 && over_cnt_q + 16'd1 == 16'(OVER_FRAMES)) begin
                        state_d = ST_TITLE;
                    end else begin
                        over_cnt_d = over_cnt_q + 16'd1;
                        if (blink_cnt_q + 16'd1 == 16'(BLINK_FRAMES)) begin
                            blink_cnt_d = 16'd0;
                            blink_on_d  = ~blink_on_q;
                        end else begin
                            blink_cnt_d = blink_cnt_q + 16'd1;
                        end
                    end
                end
                default: state_d = ST_TITLE;
            endcase
        end
    end

    // Region decode and glyph addressing; score beats GAME OVER beats logo.
    always_comb begin
        score_hit = (x < 10'd640) && (y < 10'd480) && (state_q != ST_TITLE) &&
                    ({22'd0, y} >= 32'(SCORE_Y)) && ({22'd0, y} < 32'(SCORE_Y + 32));
        over_hit  = (x < 10'd640) && (y < 10'd480) && (state_q == ST_OVER) && blink_on_q &&
                    (y[9:6] == 4'd3) && (x[9:5] >= 5'd5) && (x[9:5] <= 5'd13);
        logo_hit  = (x < 10'd640) && (y < 10'd480) && (state_q == ST_TITLE) &&
                    (y[9:7] == 3'd2) && (x[9:6] >= 4'd3) && (x[9:6] <= 4'd6);
        // Both regions sit below x=512, so the low column bits are enough to index.
        oidx    = x[8:5] - 4'd5;
        lidx    = x[7:6] - 2'd3;
        char_s0 = 7'h00;
        row_s0  = 4'd0;
        bit_s0  = 3'd0;
        rgb_s0  = BG_RGB;
        if (score_hit) begin
            char_s0 = score_char(x[9:4], score_a, score_b);
            row_s0  = 4'((y - 10'(SCORE_Y)) >> 1);
            bit_s0  = x[3:1];
            rgb_s0  = SCORE_RGB;
        end else if (over_hit) begin
            char_s0 = over_char(oidx);
            row_s0  = y[5:2];
            bit_s0  = x[4:2];
            rgb_s0  = OVER_RGB;
        end else if (logo_hit) begin
            char_s0 = logo_char(lidx);
            row_s0  = y[6:3];
            bit_s0  = x[5:3];
            rgb_s0  = LOGO_RGB;
        end
    end

    assign rom_addr_o = {char_s0, row_s0};

    // Stage 1: hold region flags, bit index and colour while the ROM reads the glyph row.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            on_p1_q  <= 3'b000;
            bit_p1_q <= 3'd0;
            rgb_p1_q <= BG_RGB;
        end else begin
            on_p1_q  <= {logo_hit, score_hit, over_hit};
            bit_p1_q <= bit_s0;
            rgb_p1_q <= rgb_s0;
        end
    end

    // Stage 2: pick the glyph bit (MSB is leftmost pixel) and register the outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            text_on_q  <= 3'b000;
            text_rgb_q <= BG_RGB;
        end else begin
            text_on_q  <= on_p1_q;
            text_rgb_q <= rom_data_i[~bit_p1_q] ? rgb_p1_q : BG_RGB;
        end
    end

    assign text_on  = text_on_q;
    assign text_rgb = text_rgb_q;

endmodule
